data_mem_param: RTL and testbench

Parametrised data-memory controller for the RV32I core's load/store path. It sits between the MEM stage and a block-RAM word array. It performs byte, halfword and word loads with sign or zero extension, and stores using read-modify-write. It maps an LED output register into the address space and flags misaligned accesses. The CPU is held with `clk_stall` while multi-cycle accesses complete.

---
 rtl/memory_pkg.sv | 39 +++
 rtl/data_mem_lane_unit.sv | 40 ++++
 rtl/data_mem_param.sv | 125 ++++++++++++
 tb/tb_data_mem_param.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared encodings for the data-memory controller: access descriptor bits,
// access sizes, controller states and the default LED register address.
package memory_pkg;

  localparam int unsigned SM_SIGNED = 3;
  localparam int unsigned SM_WORD   = 2;
  localparam int unsigned SM_HALF   = 1;

  localparam logic [31:0] LED_ADDR_DEFAULT = 32'h0000_2000;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RD     = 2'd1,
    S_RMW_RD = 2'd2,
    S_RMW_WR = 2'd3
  } state_t;

  // Word wins over halfword; bit 0 of the descriptor carries no meaning.
  function automatic access_size_t decode_size(input logic [3:0] mask);
    access_size_t sz;
    casez (mask)
      4'b?1??: sz = SZ_WORD;
      4'b?01?: sz = SZ_HALF;
      default: sz = SZ_BYTE;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(input access_size_t sz, input logic [1:0] off);
    return ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/data_mem_lane_unit.sv
// Combinational byte-lane logic: load extraction/extension and store merge
// for a single 32-bit word.
module data_mem_lane_unit
  import memory_pkg::*;
(
  input  logic [31:0]  word,
  input  logic [1:0]   offset,
  input  access_size_t size,
  input  logic         is_signed,
  input  logic [31:0]  store_data,
  output logic [31:0]  load_val,
  output logic [31:0]  merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    load_val = word;
    merged   = word;
    case (size)
      SZ_BYTE: begin
        load_val = {{24{is_signed & byte_sel[7]}}, byte_sel};
        merged[{offset, 3'b000} +: 8] = store_data[7:0];
      end
      SZ_HALF: begin
        load_val = {{16{is_signed & half_sel[15]}}, half_sel};
        if (offset[1]) merged[31:16] = store_data[15:0];
        else           merged[15:0]  = store_data[15:0];
      end
      default: begin
        load_val = word;
        merged   = store_data;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_param.sv
// Data-memory controller for the load/store path: sync single-port RAM with
// read-modify-write sub-word stores, memory-mapped LED register, misalign reject.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | accept requests; LED and misaligned accesses finish here
// S_RD     | RAM word available, load result registered on exit
// S_RMW_RD | RAM word available, merged store word latched on exit
// S_RMW_WR | merged word written to the RAM on exit
module data_mem_param
  import memory_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter logic [31:0] LED_ADDR = LED_ADDR_DEFAULT,
  parameter int unsigned LED_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      write_data,
  input  logic             memwrite,
  input  logic             memread,
  input  logic [3:0]       sign_mask,
  output logic [31:0]      read_data,
  output logic [LED_W-1:0] led,
  output logic             clk_stall,
  output logic             misaligned
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_t       state;
  logic [AW-1:0] req_idx;
  logic [1:0]   req_off;
  access_size_t req_size;
  logic         req_signed;
  logic [31:0]  req_wdata;

  logic [31:0]  mem [DEPTH];
  logic [31:0]  mem_q;
  logic [31:0]  merged_q;
  logic [31:0]  load_val;
  logic [31:0]  merged;

  access_size_t in_size;
  logic         in_misal;
  logic         in_led;
  logic [AW-1:0] in_idx;
  logic [AW-1:0] ram_idx;

  assign in_size  = decode_size(sign_mask);
  assign in_misal = is_misaligned(in_size, addr[1:0]);
  assign in_led   = (addr == LED_ADDR);
  assign in_idx   = addr[AW+1:2];
  // In IDLE the RAM is addressed straight from the request so data is ready next cycle.
  assign ram_idx  = (state == S_IDLE) ? in_idx : req_idx;

  always_ff @(posedge clk) begin
    if (state == S_RMW_WR) mem[req_idx] <= merged_q;
    mem_q <= mem[ram_idx];
  end

  data_mem_lane_unit u_lane (
    .word       (mem_q),
    .offset     (req_off),
    .size       (req_size),
    .is_signed  (req_signed),
    .store_data (req_wdata),
    .load_val   (load_val),
    .merged     (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      read_data  <= '0;
      led        <= '0;
      clk_stall  <= 1'b0;
      misaligned <= 1'b0;
      req_idx    <= '0;
      req_off    <= '0;
      req_size   <= SZ_BYTE;
      req_signed <= 1'b0;
      req_wdata  <= '0;
      merged_q   <= '0;
    end else begin
      misaligned <= 1'b0;
      case (state)
        S_IDLE: begin
          if (memread || memwrite) begin
            if (in_misal) begin
              misaligned <= 1'b1;
            end else if (in_led) begin
              if (memwrite) led       <= write_data[LED_W-1:0];
              else          read_data <= 32'(led);
            end else begin
              req_idx    <= in_idx;
              req_off    <= addr[1:0];
              req_size   <= in_size;
              req_signed <= sign_mask[SM_SIGNED];
              req_wdata  <= write_data;
              clk_stall  <= 1'b1;
              state      <= memwrite ? S_RMW_RD : S_RD;
            end
          end
        end
        S_RD: begin
          read_data <= load_val;
          clk_stall <= 1'b0;
          state     <= S_IDLE;
        end
        S_RMW_RD: begin
          merged_q <= merged;
          state    <= S_RMW_WR;
        end
        S_RMW_WR: begin
          clk_stall <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_param.sv
// Directed-vector bench for data_mem_param: table of load/store accesses with
// hand-computed results, plus reset-abort and pulse-width sequences.
module tb_data_mem_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic [7:0]  led;
  logic        clk_stall;
  logic        misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_param #(.DEPTH(1024), .LED_ADDR(32'h2000), .LED_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .write_data (write_data),
    .memwrite   (memwrite),
    .memread    (memread),
    .sign_mask  (sign_mask),
    .read_data  (read_data),
    .led        (led),
    .clk_stall  (clk_stall),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  mask;
    logic [31:0] exp_rd;
    int          exp_stall;
    logic        exp_mis;
    logic [7:0]  exp_led;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rd, logic wr, logic [31:0] a, logic [31:0] wd,
                              logic [3:0] mask, logic [31:0] exp_rd, int exp_stall,
                              logic exp_mis, logic [7:0] exp_led);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.mask = mask;
    v.exp_rd = exp_rd; v.exp_stall = exp_stall; v.exp_mis = exp_mis; v.exp_led = exp_led;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where clk_stall is low.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] mask,
                           output int stalls, output logic mis);
    memread = rd; memwrite = wr; addr = a; write_data = wd; sign_mask = mask;
    @(negedge clk);
    memread = 1'b0; memwrite = 1'b0; addr = '0; write_data = '0; sign_mask = '0;
    mis = misaligned;
    stalls = 0;
    while (clk_stall && stalls < 8) begin
      stalls++;
      @(negedge clk);
    end
  endtask

  initial begin
    int   st;
    logic mis;

    reset = 1'b1; addr = '0; write_data = '0; memwrite = 1'b0; memread = 1'b0; sign_mask = '0;
    repeat (2) @(negedge clk);
    chk("reset_read_data", read_data, 32'h0);
    chk("reset_led", {24'h0, led}, 32'h0);
    chk("reset_stall", {31'h0, clk_stall}, 32'h0);
    chk("reset_misaligned", {31'h0, misaligned}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    //       rd    wr    addr        wdata          mask     exp_rd       stall mis  led
    vq.push_back(mk(1'b0, 1'b1, 32'h00, 32'h01020304, 4'b0100, 32'h00000000, 2, 1'b0, 8'h00));
    vq.push_back(mk(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b0100, 32'h00000000, 2, 1'b0, 8'h00));
    vq.push_back(mk(1'b1, 1'b0, 32'h10, 32'h0,        4'b0100, 32'hDEADBEEF, 1, 1'b0, 8'h00));
    vq.push_back(mk(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0100, 32'hDEADBEEF, 2, 1'b0, 8'h00));
    vq.push_back(mk(1'b0, 1'b1, 32'h13, 32'h00000080, 4'b0000, 32'hDEADBEEF, 2, 1'b0, 8'h00));
    vq.push_back(mk(1'b1, 1'b0, 32'h13, 32'h0,        4'b1000, 32'hFFFFFF80, 1, 1'b0, 8'h00));
    vq.push_back(mk(1'b1, 1'b0, 32'h13, 32'h0,        4'b0000, 32'h00000080, 1, 1'b0, 8'h00));
    vq.push_back(mk(1'b1, 1'b0, 32'h10, 32'h0,        4'b0100, 32'h80223344, 1, 1'b0, 8'h00));
    vq.push_back(mk(1'b0, 1'b1, 32'h20, 32'h55667788, 4'b0100, 32'h80223344, 2, 1'b0, 8'h00));
    vq.push_back(mk(1'b0, 1'b1, 32'h22, 32'h0000ABCD, 4'b0010, 32'h80223344, 2, 1'b0, 8'h00));
    vq.push_back(mk(1'b1, 1'b0, 32'h22, 32'h0,        4'b1010, 32'hFFFFABCD, 1, 1'b0, 8'h00));
    vq.push_back(mk(1'b1, 1'b0, 32'h20, 32'h0,        4'b0100, 32'hABCD7788, 1, 1'b0, 8'h00));
    vq.push_back(mk(1'b1, 1'b0, 32'h20, 32'h0,        4'b0010, 32'h00007788, 1, 1'b0, 8'h00));
    vq.push_back(mk(1'b1, 1'b0, 32'h21, 32'h0,        4'b1000, 32'h00000077, 1, 1'b0, 8'h00));
    vq.push_back(mk(1'b1, 1'b0, 32'h05, 32'h0,        4'b0100, 32'h00000077, 0, 1'b1, 8'h00));
    vq.push_back(mk(1'b0, 1'b1, 32'h03, 32'h0000FFFF, 4'b0010, 32'h00000077, 0, 1'b1, 8'h00));
    vq.push_back(mk(1'b1, 1'b0, 32'h00, 32'h0,        4'b0100, 32'h01020304, 1, 1'b0, 8'h00));
    vq.push_back(mk(1'b1, 1'b0, 32'h1010, 32'h0,      4'b0100, 32'h80223344, 1, 1'b0, 8'h00));
    vq.push_back(mk(1'b0, 1'b1, 32'h2000, 32'h000000A5, 4'b0100, 32'h80223344, 0, 1'b0, 8'hA5));
    vq.push_back(mk(1'b1, 1'b0, 32'h2000, 32'h0,      4'b0100, 32'h000000A5, 0, 1'b0, 8'hA5));
    vq.push_back(mk(1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 4'b0100, 32'h000000A5, 2, 1'b0, 8'hA5));
    vq.push_back(mk(1'b0, 1'b1, 32'h31, 32'h00000012, 4'b0000, 32'h000000A5, 2, 1'b0, 8'hA5));
    vq.push_back(mk(1'b1, 1'b0, 32'h30, 32'h0,        4'b0100, 32'hCAFE120D, 1, 1'b0, 8'hA5));
    vq.push_back(mk(1'b1, 1'b0, 32'h31, 32'h0,        4'b0000, 32'h00000012, 1, 1'b0, 8'hA5));
    vq.push_back(mk(1'b1, 1'b0, 32'h32, 32'h0,        4'b1000, 32'hFFFFFFFE, 1, 1'b0, 8'hA5));
    vq.push_back(mk(1'b0, 1'b1, 32'h40, 32'h0BADF00D, 4'b0100, 32'hFFFFFFFE, 2, 1'b0, 8'hA5));
    vq.push_back(mk(1'b1, 1'b0, 32'h40, 32'h0,        4'b0100, 32'h0BADF00D, 1, 1'b0, 8'hA5));
    vq.push_back(mk(1'b0, 1'b1, 32'h1FFE, 32'h0000BEEF, 4'b0010, 32'h0BADF00D, 2, 1'b0, 8'hA5));
    vq.push_back(mk(1'b1, 1'b0, 32'h0FFE, 32'h0,      4'b0010, 32'h0000BEEF, 1, 1'b0, 8'hA5));
    vq.push_back(mk(1'b1, 1'b0, 32'h10, 32'h0,        4'b1100, 32'h80223344, 1, 1'b0, 8'hA5));

    foreach (vq[i]) begin
      do_access(vq[i].rd, vq[i].wr, vq[i].a, vq[i].wd, vq[i].mask, st, mis);
      chk($sformatf("v%0d_stall_cycles", i), st, vq[i].exp_stall);
      chk($sformatf("v%0d_misaligned", i), {31'h0, mis}, {31'h0, vq[i].exp_mis});
      chk($sformatf("v%0d_read_data", i), read_data, vq[i].exp_rd);
      chk($sformatf("v%0d_led", i), {24'h0, led}, {24'h0, vq[i].exp_led});
    end

    // Misaligned pulse lasts exactly one cycle.
    memread = 1'b1; addr = 32'h06; sign_mask = 4'b0100;
    @(negedge clk);
    memread = 1'b0; addr = '0; sign_mask = '0;
    chk("mis_pulse_high", {31'h0, misaligned}, 32'h1);
    chk("mis_no_stall", {31'h0, clk_stall}, 32'h0);
    @(negedge clk);
    chk("mis_pulse_low", {31'h0, misaligned}, 32'h0);

    // Reset during RMW_RD of a store to 0x40 aborts the write.
    memwrite = 1'b1; addr = 32'h40; write_data = 32'hFFFFFFFF; sign_mask = 4'b0100;
    @(negedge clk);
    memwrite = 1'b0; addr = '0; write_data = '0; sign_mask = '0;
    chk("abort_stall_before", {31'h0, clk_stall}, 32'h1);
    reset = 1'b1;
    #1;
    chk("abort_stall_now", {31'h0, clk_stall}, 32'h0);
    chk("abort_led", {24'h0, led}, 32'h0);
    chk("abort_read_data", read_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 4'b0100, st, mis);
    chk("abort_stall_cycles", st, 1);
    chk("abort_old_value", read_data, 32'h0BADF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
